// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | uart_tx_arbiter: round-robin message arbiter for one UART transmitter |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module uart_tx_arbiter #(
  parameter int MAX_BURST    = 16,
  parameter int IDLE_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req0_data,
  input  logic       req0_valid,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic [7:0] req1_data,
  input  logic       req1_valid,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       grant_id
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int IW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
  localparam logic [IW-1:0] IDLE_LAST  = IW'(IDLE_TIMEOUT - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  state_t          state;
  logic            owner;
  logic            last_owner;
  logic [BW-1:0]   burst_cnt;
  logic [IW-1:0]   idle_cnt;

  logic            own_valid;
  logic            own_last;
  logic [7:0]      own_data;
  logic            accept;

  assign own_valid  = owner ? req1_valid : req0_valid;
  assign own_last   = owner ? req1_last  : req0_last;
  assign own_data   = owner ? req1_data  : req0_data;

  // Only one byte may be in flight, so the owner waits for the UART to drain it.
  assign req0_ready = (state == ST_LOCK) && !owner && !tx_valid;
  assign req1_ready = (state == ST_LOCK) &&  owner && !tx_valid;
  assign accept     = (state == ST_LOCK) && own_valid && !tx_valid;

  assign busy       = (state == ST_LOCK);
  assign grant_id   = owner;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      burst_cnt  <= '0;
      idle_cnt   <= '0;
      tx_data    <= 8'h00;
      tx_valid   <= 1'b0;
    end else begin
      if (tx_valid && tx_ready) begin
        tx_valid <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (req0_valid || req1_valid) begin
            state     <= ST_LOCK;
            owner     <= (req0_valid && req1_valid) ? ~last_owner : req1_valid;
            burst_cnt <= '0;
            idle_cnt  <= '0;
          end
        end
        ST_LOCK: begin
          if (accept) begin
            tx_data   <= own_data;
            tx_valid  <= 1'b1;
            burst_cnt <= burst_cnt + 1'b1;
            idle_cnt  <= '0;
            if (own_last || (burst_cnt == BURST_LAST)) begin
              state      <= ST_IDLE;
              last_owner <= owner;
            end
          end else if (!own_valid) begin
            // A silent owner gives up the transmitter after IDLE_TIMEOUT cycles.
            if (idle_cnt == IDLE_LAST) begin
              state      <= ST_IDLE;
              last_owner <= owner;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end else begin
            idle_cnt <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// Self-checking bench for uart_tx_arbiter: directed scenarios plus random traffic
// compared every cycle against a queue-based behavioural model.
module tb_uart_tx_arbiter;

  localparam int MAX_BURST    = 4;
  localparam int IDLE_TIMEOUT = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req0_data = 8'h00;
  logic       req0_valid = 1'b0;
  logic       req0_last = 1'b0;
  logic       req0_ready;
  logic [7:0] req1_data = 8'h00;
  logic       req1_valid = 1'b0;
  logic       req1_last = 1'b0;
  logic       req1_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b1;
  logic       busy;
  logic       grant_id;

  uart_tx_arbiter #(
    .MAX_BURST   (MAX_BURST),
    .IDLE_TIMEOUT(IDLE_TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req0_data (req0_data),
    .req0_valid(req0_valid),
    .req0_last (req0_last),
    .req0_ready(req0_ready),
    .req1_data (req1_data),
    .req1_valid(req1_valid),
    .req1_last (req1_last),
    .req1_ready(req1_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Stimulus sources: each entry is {last, data}.
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [7:0] uart_log[$];
  logic [7:0] exp_bytes[$];

  bit rand_en   = 0;
  bit rand_txr  = 0;
  int hold_until = 0;
  int acc0_cyc  = -1;
  int idle_cyc  = -1;

  // Reference model: grant bookkeeping plus a queue for the byte in flight.
  bit         m_lock  = 0;
  bit         m_owner = 0;
  bit         m_prev  = 1;
  int         m_count = 0;
  int         m_quiet = 0;
  logic [7:0] m_data  = 8'h00;
  logic [7:0] m_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit m_rdy(input bit who);
    return m_lock && (m_owner == who) && (m_q.size() == 0);
  endfunction

  task automatic m_release();
    m_lock = 0;
    m_prev = m_owner;
  endtask

  task automatic model_step();
    bit         r_own;
    bit         ov;
    bit         ol;
    logic [7:0] od;
    if (rst) begin
      m_lock = 0; m_owner = 0; m_prev = 1; m_count = 0; m_quiet = 0;
      m_data = 8'h00; m_q.delete();
      return;
    end
    r_own = m_rdy(m_owner);
    if (m_q.size() != 0 && tx_ready) void'(m_q.pop_front());
    if (!m_lock) begin
      if (req0_valid || req1_valid) begin
        m_owner = (req0_valid && req1_valid) ? !m_prev : req1_valid;
        m_lock  = 1;
        m_count = 0;
        m_quiet = 0;
      end
    end else begin
      ov = m_owner ? req1_valid : req0_valid;
      ol = m_owner ? req1_last  : req0_last;
      od = m_owner ? req1_data  : req0_data;
      if (ov && r_own) begin
        m_q.push_back(od);
        m_data  = od;
        m_count = m_count + 1;
        m_quiet = 0;
        if (ol || m_count == MAX_BURST) m_release();
      end else if (!ov) begin
        m_quiet = m_quiet + 1;
        if (m_quiet == IDLE_TIMEOUT) m_release();
      end else begin
        m_quiet = 0;
      end
    end
  endtask

  task automatic tick();
    check_eq("busy",     busy,       m_lock);
    check_eq("grant_id", grant_id,   m_owner);
    check_eq("tx_valid", tx_valid,   m_q.size() != 0);
    check_eq("tx_data",  tx_data,    m_data);
    check_eq("ready0",   req0_ready, m_rdy(0));
    check_eq("ready1",   req1_ready, m_rdy(1));
    if (!rst && tx_valid && tx_ready) uart_log.push_back(tx_data);
    model_step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1; req0_valid = 0; req1_valid = 0;
    tick();
    rst = 0;
  endtask

  task automatic run(input int max_cyc, input bit stop_on_pending, input bit bound_ok);
    int n = 0;
    bit a0, a1, rel_chk = 0;
    forever begin
      if (stop_on_pending && m_q.size() != 0) break;
      if (!stop_on_pending && q0.size() == 0 && q1.size() == 0 && !m_lock && m_q.size() == 0) break;
      if (n >= max_cyc) begin
        if (!bound_ok) check_eq("run_bound", n, 0);
        break;
      end
      req0_valid = (q0.size() > 0) && (!rand_en || $urandom_range(0, 9) < 8);
      req1_valid = (q1.size() > 0) && (!rand_en || $urandom_range(0, 9) < 8);
      if (q0.size() > 0) begin req0_data = q0[0][7:0]; req0_last = q0[0][8]; end
      if (q1.size() > 0) begin req1_data = q1[0][7:0]; req1_last = q1[0][8]; end
      tx_ready = (cyc < hold_until) ? 1'b0 : (rand_txr ? 1'($urandom_range(0, 1)) : 1'b1);
      a0 = req0_valid && m_rdy(0);
      a1 = req1_valid && m_rdy(1);
      if (rel_chk) check_eq("busy_after_last", busy, 0);
      rel_chk = (a0 && req0_last) || (a1 && req1_last);
      if (a0) acc0_cyc = cyc;
      if (!busy && idle_cyc <= acc0_cyc) idle_cyc = cyc;
      tick();
      n++;
      if (a0) void'(q0.pop_front());
      if (a1) void'(q1.pop_front());
    end
  endtask

  task automatic check_log(input string tag);
    check_eq({tag, "_len"}, uart_log.size(), exp_bytes.size());
    for (int i = 0; i < exp_bytes.size() && i < uart_log.size(); i++)
      check_eq(tag, uart_log[i], exp_bytes[i]);
    uart_log.delete();
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_tx_valid", tx_valid, 0);
    check_eq("rst_grant", grant_id, 0);

    // Single message from requester 0.
    q0.push_back({1'b0, 8'h48}); q0.push_back({1'b1, 8'h69});
    run(100, 0, 0);
    exp_bytes = {8'h48, 8'h69};
    check_log("single_msg");
    check_eq("single_grant", grant_id, 0);

    // Tie from reset, then alternation across two message pairs.
    do_reset();
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 3; i++) begin
        q0.push_back({i == 2, 8'(8'hA0 + i)});
        q1.push_back({i == 2, 8'(8'hB0 + i)});
      end
      run(200, 0, 0);
      exp_bytes = {8'hA0, 8'hA1, 8'hA2, 8'hB0, 8'hB1, 8'hB2};
      check_log("alternation");
    end

    // Burst limit: requester 1 streams without last, requester 0 joins later.
    do_reset();
    for (int i = 0; i < 10; i++) q1.push_back({1'b0, 8'(8'hC0 + i)});
    run(2, 0, 1);
    q0.push_back({1'b0, 8'hD0}); q0.push_back({1'b1, 8'hD1});
    run(300, 0, 0);
    exp_bytes = {8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hD0, 8'hD1,
                 8'hC4, 8'hC5, 8'hC6, 8'hC7, 8'hC8, 8'hC9};
    check_log("burst");

    // Idle timeout: requester 0 stalls after one non-last byte.
    do_reset();
    acc0_cyc = -1; idle_cyc = -1;
    q0.push_back({1'b0, 8'hE0});
    q1.push_back({1'b1, 8'hF0});
    run(200, 0, 0);
    check_eq("timeout_cycles", idle_cyc - (acc0_cyc + 1), 8);
    exp_bytes = {8'hE0, 8'hF0};
    check_log("timeout");

    // Backpressure: UART stalls for 100 cycles.
    do_reset();
    hold_until = cyc + 102;
    q0.push_back({1'b0, 8'h11}); q0.push_back({1'b0, 8'h22}); q0.push_back({1'b1, 8'h33});
    run(400, 0, 0);
    hold_until = 0;
    exp_bytes = {8'h11, 8'h22, 8'h33};
    check_log("backpressure");

    // Reset while a byte is pending mid-message.
    do_reset();
    hold_until = cyc + 1000;
    q0.push_back({1'b0, 8'h31}); q0.push_back({1'b0, 8'h32}); q0.push_back({1'b1, 8'h33});
    run(100, 1, 0);
    check_eq("pre_rst_tx_valid", tx_valid, 1);
    do_reset();
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_tx_valid", tx_valid, 0);
    check_eq("midrst_tx_data", tx_data, 8'h00);
    check_eq("midrst_ready0", req0_ready, 0);
    hold_until = 0;
    q0.delete(); q1.delete(); uart_log.delete();
    q0.push_back({1'b1, 8'h5A}); q1.push_back({1'b1, 8'h5B});
    run(100, 0, 0);
    exp_bytes = {8'h5A, 8'h5B};
    check_log("after_rst");

    // Random traffic, checked cycle by cycle against the model.
    rand_en = 1; rand_txr = 1;
    for (int r = 0; r < 4; r++) begin
      for (int w = 0; w < 2; w++) begin
        int nm = $urandom_range(1, 3);
        for (int m = 0; m < nm; m++) begin
          int len = $urandom_range(1, 6);
          bit nolast = ($urandom_range(0, 3) == 0);
          for (int b = 0; b < len; b++) begin
            logic [8:0] e;
            e[7:0] = 8'($urandom);
            e[8]   = (b == len - 1) && !nolast;
            if (w == 0) q0.push_back(e); else q1.push_back(e);
          end
        end
      end
      run(3000, 0, 0);
    end
    uart_log.delete();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single on-chip UART transmitter between two byte-stream requesters: the CPU memory-mapped store path (requester 0) and a hardware console/status source (requester 1). It grants the transmitter to one requester for a whole message (bytes up to and including one tagged `last`), alternating ownership round-robin between messages. It bounds each ownership by a burst limit and an idle timeout so neither requester can starve the other. It sits between the requesters and the UART `data_in`/`data_in_valid`/`data_in_ready` ports.

## Interface
- `MAX_BURST`, 16: maximum bytes per grant before forced release; legal range ≥1.
- `IDLE_TIMEOUT`, 64: consecutive cycles the owner may hold the grant with its valid low before forced release; legal range ≥1.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `req0_data` in 8: requester 0 byte.
- `req0_valid` in 1: requester 0 byte present.
- `req0_last` in 1: requester 0 byte ends its message.
- `req0_ready` out 1: requester 0 byte accepted this cycle when high with valid.
- `req1_data`, `req1_valid`, `req1_last` in 8/1/1: same as requester 0.
- `req1_ready` out 1: same as requester 0.
- `tx_data` out 8: byte to UART (registered).
- `tx_valid` out 1: byte to UART pending (registered).
- `tx_ready` in 1: UART accepts byte.
- `busy` out 1: a grant is held (state LOCK).
- `grant_id` out 1: current or most recent owner.

## Operation
- State register, two states:
  - IDLE: no owner.
  - LOCK: `owner` holds the transmitter.
- Registers: `owner`, `last_owner`, `burst_cnt` (width clog2(MAX_BURST+1)), `idle_cnt`, output byte register (`tx_data`, `tx_valid`).
- IDLE with any `reqX_valid`:
  - Pick the single valid requester.
  - If both are valid, pick `!last_owner`.
  - Next cycle: state LOCK, `owner` = winner, `burst_cnt` = 0, `idle_cnt` = 0.
  - No byte is accepted in the arbitration cycle.
- `reqX_ready` = (state == LOCK) && (owner == X) && !`tx_valid`. The non-owner ready is always 0.
- Accept (owner valid && ready):
  - `tx_data` ← owner data, `tx_valid` ← 1.
  - `burst_cnt` += 1, `idle_cnt` ← 0.
- Release: on an accept with `last` = 1, or with `burst_cnt` == MAX_BURST−1:
  - Next state is IDLE.
  - `last_owner` ← owner.
- Timeout:
  - In LOCK, `idle_cnt` increments each cycle the owner valid is low, and clears when owner valid is high.
  - When `idle_cnt` reaches IDLE_TIMEOUT−1 with owner valid still low: next state IDLE, `last_owner` ← owner.
- Output handshake: `tx_valid` clears on `tx_valid && tx_ready` unless reloaded in the same cycle. Reload cannot coincide, because ready requires `!tx_valid`.
- IDLE may arbitrate while `tx_valid` is still pending. The new owner waits for the pending byte to drain.
- `busy` = (state == LOCK). `grant_id` = `owner`.
- Requester 1 valid while requester 0 is mid-message: ignored until release; it wins the next arbitration if requester 0 is also valid.

## Timing
- Reset values: state IDLE, `tx_valid` 0, `tx_data` 8'h00, `busy` 0, `grant_id` 0, `last_owner` 1 (requester 0 wins the first tie), counters 0, `req0_ready`/`req1_ready` 0.
- Reset mid-message: any pending `tx_valid` byte is dropped and the grant is released. Requesters must restart their message.
- Latency for a fresh message with the transmitter free:
  - valid rises in cycle N (IDLE).
  - `reqX_ready` = 1 in cycle N+1.
  - Accept at the end of N+1.
  - `tx_valid` = 1 in N+2.
- Per-byte throughput: one byte per 2 cycles at best (accept, then UART handshake clears `tx_valid`). In practice it is limited by UART `tx_ready`.
- After release: at least one IDLE cycle between grants.

## Test plan
- Single message: requester 0 sends 8'h48, 8'h69 (`last` on 8'h69), `tx_ready` tied 1.
  - UART sees 48 then 69.
  - `busy` falls the cycle after the 69 accept.
  - `grant_id` = 0.
- Tie and alternation: both requesters hold 3-byte messages (A0..A2, B0..B2) from reset.
  - Order is A0 A1 A2 B0 B1 B2.
  - A second pair of messages gives A then B again.
- Burst limit: MAX_BURST = 4, requester 1 streams 10 bytes without `last` while requester 0 waits.
  - 4 bytes from requester 1, then requester 0's message, then requester 1 resumes.
- Timeout: IDLE_TIMEOUT = 8, requester 0 sends one non-last byte then drops valid.
  - `busy` falls exactly 8 cycles after valid drops.
  - Requester 1, already valid, is granted next.
- Backpressure: `tx_ready` held 0 for 100 cycles with `tx_valid` = 1.
  - `tx_data` stable, owner ready = 0.
  - On `tx_ready` = 1, the next byte is accepted the following cycle with no byte lost or duplicated.
- Reset mid-message: assert `rst` while `tx_valid` = 1 during a grant.
  - The next cycle shows all outputs at their reset values.
  - Requester 0 then wins a tie.
